// File: rtl/seq_detect_ctrl.sv
// Programmable serial-pattern detector with start/stop sequencing, match counter and threshold irq.
// Latency: out/irq register one clock after the edge that samples the completing bit.
// Backpressure: none on the serial input; cfg_ready is low while a run is active, and writes made then are dropped.
//
// Ports:
//   clk, reset          rising-edge clock, asynchronous active-high reset
//   cfg_valid/cfg_ready config write handshake (pattern, len, overlap, thresh)
//   cfg_pattern         pattern, bit 0 = most recent serial bit
//   cfg_len             pattern length (0 -> 1, >MAXLEN -> MAXLEN)
//   cfg_overlap         1 = matches may share bits
//   cfg_thresh          match count that ends a run, 0 = never
//   start, stop         run control (stop wins in RUN, start wins otherwise)
//   in_valid, in        qualified serial data bit
//   out                 one-cycle match flag
//   busy                high while in RUN
//   match_count         saturating match count of current/last run
//   irq                 one-cycle pulse when the threshold is reached
module seq_detect_ctrl #(
  parameter int MAXLEN = 8,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [MAXLEN-1:0] cfg_pattern,
  input  logic [3:0]        cfg_len,
  input  logic              cfg_overlap,
  input  logic [CNT_W-1:0]  cfg_thresh,
  input  logic              start,
  input  logic              stop,
  input  logic              in_valid,
  input  logic              in,
  output logic              out,
  output logic              busy,
  output logic [CNT_W-1:0]  match_count,
  output logic              irq
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [MAXLEN-1:0] PAT_RST = MAXLEN'(3);
  localparam logic [3:0]        LEN_MAX = 4'(MAXLEN);

  state_t            state_q, state_d;
  logic [MAXLEN-1:0] pattern_q, pattern_d;
  logic [3:0]        len_q, len_d;
  logic              overlap_q, overlap_d;
  logic [CNT_W-1:0]  thresh_q, thresh_d;
  logic [MAXLEN-1:0] hist_q, hist_d;
  logic [3:0]        fill_q, fill_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              out_q, out_d;
  logic              irq_q, irq_d;

  // Candidate values for a valid bit arriving this cycle.
  logic [MAXLEN-1:0] hist_shift;
  logic [MAXLEN-1:0] len_mask;
  logic [3:0]        fill_inc;
  logic [CNT_W-1:0]  cnt_inc;
  logic              hit;

  always_comb begin
    hist_shift = {hist_q[MAXLEN-2:0], in};
    fill_inc   = (fill_q >= LEN_MAX) ? fill_q : fill_q + 4'd1;
    cnt_inc    = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);
    len_mask   = '0;
    for (int i = 0; i < MAXLEN; i++) begin
      len_mask[i] = (i < int'(len_q));
    end
    // Only the newest len bits take part, and only once len bits have been seen.
    hit = (fill_inc >= len_q) && ((hist_shift & len_mask) == (pattern_q & len_mask));
  end

  always_comb begin
    state_d   = state_q;
    pattern_d = pattern_q;
    len_d     = len_q;
    overlap_d = overlap_q;
    thresh_d  = thresh_q;
    hist_d    = hist_q;
    fill_d    = fill_q;
    cnt_d     = cnt_q;
    out_d     = 1'b0;
    irq_d     = 1'b0;

    // Config is latched whenever no run is active; a same-cycle start then
    // runs with the freshly written values.
    if (cfg_valid && (state_q != RUN)) begin
      pattern_d = cfg_pattern;
      overlap_d = cfg_overlap;
      thresh_d  = cfg_thresh;
      if (cfg_len == 4'd0) begin
        len_d = 4'd1;
      end else if (cfg_len > LEN_MAX) begin
        len_d = LEN_MAX;
      end else begin
        len_d = cfg_len;
      end
    end

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = RUN;
          hist_d  = '0;
          fill_d  = 4'd0;
          cnt_d   = '0;
        end
      end
      RUN: begin
        if (stop) begin
          state_d = IDLE;
        end else if (in_valid) begin
          hist_d = hist_shift;
          fill_d = fill_inc;
          if (hit) begin
            out_d = 1'b1;
            cnt_d = cnt_inc;
            // Non-overlapping: forget the bits already consumed by this match.
            if (!overlap_q) begin
              fill_d = 4'd0;
            end
            if ((thresh_q != '0) && (cnt_inc == thresh_q)) begin
              irq_d   = 1'b1;
              state_d = DONE;
            end
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      pattern_q <= PAT_RST;
      len_q     <= 4'd2;
      overlap_q <= 1'b1;
      thresh_q  <= '0;
      hist_q    <= '0;
      fill_q    <= 4'd0;
      cnt_q     <= '0;
      out_q     <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pattern_q <= pattern_d;
      len_q     <= len_d;
      overlap_q <= overlap_d;
      thresh_q  <= thresh_d;
      hist_q    <= hist_d;
      fill_q    <= fill_d;
      cnt_q     <= cnt_d;
      out_q     <= out_d;
      irq_q     <= irq_d;
    end
  end

  assign cfg_ready   = (state_q != RUN);
  assign busy        = (state_q == RUN);
  assign out         = out_q;
  assign irq         = irq_q;
  assign match_count = cnt_q;

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Bench for seq_detect_ctrl: directed bit streams with expected match pulses queued by stimulus
// and checked by an independent monitor on every out pulse.
// No flow control on the serial side; cfg_ready checked directly.
module tb_seq_detect_ctrl;

  localparam int MAXLEN = 8;
  localparam int CNT_W  = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic              cfg_valid;
  logic              cfg_ready;
  logic [MAXLEN-1:0] cfg_pattern;
  logic [3:0]        cfg_len;
  logic              cfg_overlap;
  logic [CNT_W-1:0]  cfg_thresh;
  logic              start;
  logic              stop;
  logic              in_valid;
  logic              in_bit;
  logic              out;
  logic              busy;
  logic [CNT_W-1:0]  match_count;
  logic              irq;

  seq_detect_ctrl #(.MAXLEN(MAXLEN), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_pattern(cfg_pattern),
    .cfg_len    (cfg_len),
    .cfg_overlap(cfg_overlap),
    .cfg_thresh (cfg_thresh),
    .start      (start),
    .stop       (stop),
    .in_valid   (in_valid),
    .in         (in_bit),
    .out        (out),
    .busy       (busy),
    .match_count(match_count),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int               at;
    logic [CNT_W-1:0] cnt;
    logic             irq;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every out pulse must match the head of the expectation queue.
  always @(negedge clk) begin
    if (!reset) begin
      if (out) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_out: pulse at cycle %0d count %0d, expected no pulse", cyc, match_count);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("pulse_cycle", cyc, e.at);
          check("pulse_count", 32'(match_count), 32'(e.cnt));
          check("pulse_irq", 32'(irq), 32'(e.irq));
          check("pulse_busy", 32'(busy), 32'(!e.irq));
        end
      end else if (irq) begin
        check("irq_without_out", 32'(irq), 32'd0);
      end
    end
  end

  task automatic idle_inputs();
    cfg_valid = 1'b0;
    start     = 1'b0;
    stop      = 1'b0;
    in_valid  = 1'b0;
    in_bit    = 1'b0;
  endtask

  task automatic idle_cyc();
    @(negedge clk);
    idle_inputs();
  endtask

  // Drive one valid bit; if it completes a match, queue the expected pulse.
  task automatic bit_in(input logic b, input logic m, input int cnt, input logic irq_e);
    exp_t e;
    @(negedge clk);
    idle_inputs();
    in_valid = 1'b1;
    in_bit   = b;
    if (m) begin
      e.at  = cyc + 1;
      e.cnt = CNT_W'(cnt);
      e.irq = irq_e;
      exp_q.push_back(e);
    end
  endtask

  // Invalid cycle carrying a 1 that must be ignored.
  task automatic gap();
    @(negedge clk);
    idle_inputs();
    in_bit = 1'b1;
  endtask

  task automatic do_cfg(input logic [MAXLEN-1:0] pat, input logic [3:0] len, input logic ovl,
                        input logic [CNT_W-1:0] thr, input logic st);
    @(negedge clk);
    idle_inputs();
    cfg_valid   = 1'b1;
    cfg_pattern = pat;
    cfg_len     = len;
    cfg_overlap = ovl;
    cfg_thresh  = thr;
    start       = st;
  endtask

  task automatic do_start();
    @(negedge clk);
    idle_inputs();
    start = 1'b1;
  endtask

  task automatic do_stop();
    @(negedge clk);
    idle_inputs();
    stop = 1'b1;
  endtask

  // Let outstanding pulses arrive, then require the queue to be empty.
  task automatic drain(input string name);
    repeat (3) idle_cyc();
    check(name, exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    idle_inputs();
    cfg_pattern = '0;
    cfg_len     = 4'd0;
    cfg_overlap = 1'b0;
    cfg_thresh  = '0;
    reset       = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_out", 32'(out), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_irq", 32'(irq), 0);
    check("rst_count", 32'(match_count), 0);
    check("rst_cfg_ready", 32'(cfg_ready), 1);
    reset = 1'b0;

    // Default overlapping "11": bits 0,1,1,1,0.
    do_start();
    bit_in(1'b0, 1'b0, 0, 1'b0);
    bit_in(1'b1, 1'b0, 0, 1'b0);
    bit_in(1'b1, 1'b1, 1, 1'b0);
    bit_in(1'b1, 1'b1, 2, 1'b0);
    bit_in(1'b0, 1'b0, 0, 1'b0);
    idle_cyc();
    check("t1_busy", 32'(busy), 1);
    check("t1_cfg_ready_run", 32'(cfg_ready), 0);
    do_stop();
    drain("t1_drain");
    check("t1_count_kept", 32'(match_count), 2);
    check("t1_busy_stopped", 32'(busy), 0);

    // Pattern 101, len 3, non-overlapping.
    do_cfg(8'b101, 4'd3, 1'b0, 2'd0, 1'b0);
    check("t2_cfg_ready", 32'(cfg_ready), 1);
    do_start();
    bit_in(1'b1, 1'b0, 0, 1'b0);
    bit_in(1'b0, 1'b0, 0, 1'b0);
    bit_in(1'b1, 1'b1, 1, 1'b0);
    bit_in(1'b0, 1'b0, 0, 1'b0);
    bit_in(1'b1, 1'b0, 0, 1'b0);
    do_stop();
    drain("t2_drain");
    check("t2_count", 32'(match_count), 1);

    // Same stream, overlapping; config written together with start.
    do_cfg(8'b101, 4'd3, 1'b1, 2'd0, 1'b1);
    bit_in(1'b1, 1'b0, 0, 1'b0);
    bit_in(1'b0, 1'b0, 0, 1'b0);
    bit_in(1'b1, 1'b1, 1, 1'b0);
    bit_in(1'b0, 1'b0, 0, 1'b0);
    bit_in(1'b1, 1'b1, 2, 1'b0);
    do_stop();
    drain("t3_drain");
    check("t3_count", 32'(match_count), 2);

    // Threshold 2 with "11": irq on the 3rd bit, 4th ignored.
    do_cfg(8'b11, 4'd2, 1'b1, 2'd2, 1'b0);
    do_start();
    bit_in(1'b1, 1'b0, 0, 1'b0);
    bit_in(1'b1, 1'b1, 1, 1'b0);
    bit_in(1'b1, 1'b1, 2, 1'b1);
    bit_in(1'b1, 1'b0, 0, 1'b0);
    drain("t4_drain");
    check("t4_busy_done", 32'(busy), 0);
    check("t4_count_done", 32'(match_count), 2);
    check("t4_cfg_ready_done", 32'(cfg_ready), 1);
    do_cfg(8'b11, 4'd2, 1'b1, 2'd0, 1'b0);
    do_start();
    idle_cyc();
    check("t4_restart_count", 32'(match_count), 0);
    check("t4_restart_busy", 32'(busy), 1);
    do_stop();
    drain("t4b_drain");

    // in_valid gaps, then a dropped config write during RUN.
    do_start();
    bit_in(1'b1, 1'b0, 0, 1'b0);
    gap();
    gap();
    gap();
    bit_in(1'b1, 1'b1, 1, 1'b0);
    do_cfg(8'b0, 4'd5, 1'b0, 2'd1, 1'b0);
    check("t5_cfg_ready_run", 32'(cfg_ready), 0);
    do_stop();
    drain("t5_drain");
    // Unchanged config: "11" still matches and thresh is still 0 (no irq).
    do_start();
    bit_in(1'b1, 1'b0, 0, 1'b0);
    bit_in(1'b1, 1'b1, 1, 1'b0);
    do_stop();
    drain("t5b_drain");

    // Counter saturation at 3 with six 1s.
    do_start();
    bit_in(1'b1, 1'b0, 0, 1'b0);
    bit_in(1'b1, 1'b1, 1, 1'b0);
    bit_in(1'b1, 1'b1, 2, 1'b0);
    bit_in(1'b1, 1'b1, 3, 1'b0);
    bit_in(1'b1, 1'b1, 3, 1'b0);
    bit_in(1'b1, 1'b1, 3, 1'b0);
    do_stop();
    drain("t6_drain");
    check("t6_count_sat", 32'(match_count), 3);

    // Reset mid-run restores default config.
    do_cfg(8'b101, 4'd3, 1'b1, 2'd0, 1'b0);
    do_start();
    bit_in(1'b1, 1'b0, 0, 1'b0);
    bit_in(1'b0, 1'b0, 0, 1'b0);
    bit_in(1'b1, 1'b1, 1, 1'b0);
    bit_in(1'b0, 1'b0, 0, 1'b0);
    @(negedge clk);
    idle_inputs();
    reset = 1'b1;
    #1;
    check("t7_rst_busy", 32'(busy), 0);
    check("t7_rst_out", 32'(out), 0);
    check("t7_rst_count", 32'(match_count), 0);
    check("t7_rst_cfg_ready", 32'(cfg_ready), 1);
    exp_q.delete();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    do_start();
    bit_in(1'b1, 1'b0, 0, 1'b0);
    bit_in(1'b1, 1'b1, 1, 1'b0);
    do_stop();
    drain("t7_drain");
    check("t7_count", 32'(match_count), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion before 100000");
    $fatal(1, "watchdog expired");
  end

endmodule
